// File: rtl/relm_divider_seq.sv
// Sequential radix-4 restoring divider. It produces 2 quotient bits per cycle and supports
// signed/unsigned modes, divide-by-zero flagging and a start/busy/valid handshake.
module relm_divider_seq #(
    parameter int unsigned WD = 32,
    localparam int unsigned ITER = WD / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    input  logic          signed_in,
    input  logic [WD-1:0] n_in,
    input  logic [WD-1:0] d_in,
    output logic          busy_out,
    output logic          valid_out,
    output logic [WD-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          dz_out
);

    localparam int unsigned CW = $clog2(ITER);
    localparam int unsigned RW = WD + 2;
    localparam int unsigned TW = WD + 4;
    localparam logic [CW-1:0] CntInit = CW'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StIter, StFix} state_t;

    state_t        state_q, state_d;
    logic [WD-1:0] nsh_q, nsh_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [RW-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [WD-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          negq_q, negq_d, negr_q, negr_d;
    logic [WD-1:0] nraw_q, nraw_d;
    logic          dz_q, dz_d;
    logic          valid_d, dzo_d;
    logic [WD-1:0] qo_d, ro_d;

    logic [WD-1:0] n_abs, d_abs, rem_lo;
    logic [TW-1:0] t_val;
    logic [RW-1:0] sub_val, rem_next;
    logic [1:0]    digit;

    assign n_abs  = (signed_in && n_in[WD-1]) ? -n_in : n_in;
    assign d_abs  = (signed_in && d_in[WD-1]) ? -d_in : d_in;
    assign rem_lo = rem_q[WD-1:0];

    // Digit selection: largest multiple of |d| not exceeding the shifted partial remainder.
    always_comb begin
        t_val = {rem_q, nsh_q[WD-1 -: 2]};
        if (t_val >= TW'(d3_q)) begin
            digit   = 2'd3;
            sub_val = d3_q;
        end else if (t_val >= TW'(d2_q)) begin
            digit   = 2'd2;
            sub_val = d2_q;
        end else if (t_val >= TW'(d1_q)) begin
            digit   = 2'd1;
            sub_val = d1_q;
        end else begin
            digit   = 2'd0;
            sub_val = '0;
        end
        rem_next = RW'(t_val - TW'(sub_val));
    end

    always_comb begin
        state_d = state_q;
        nsh_d   = nsh_q;
        rem_d   = rem_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        nraw_d  = nraw_q;
        dz_d    = dz_q;
        valid_d = 1'b0;
        qo_d    = q_out;
        ro_d    = r_out;
        dzo_d   = dz_out;
        case (state_q)
            StIdle: begin
                if (start_in) begin
                    nsh_d   = n_abs;
                    rem_d   = '0;
                    d1_d    = RW'(d_abs);
                    d2_d    = RW'({d_abs, 1'b0});
                    d3_d    = RW'(d_abs) + RW'({d_abs, 1'b0});
                    quo_d   = '0;
                    cnt_d   = CntInit;
                    negq_d  = signed_in & (n_in[WD-1] ^ d_in[WD-1]);
                    negr_d  = signed_in & n_in[WD-1];
                    nraw_d  = n_in;
                    dz_d    = (d_in == '0);
                    state_d = StIter;
                end
            end
            StIter: begin
                nsh_d = nsh_q << 2;
                rem_d = rem_next;
                quo_d = {quo_q[WD-3:0], digit};
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                if (dz_q) begin
                    qo_d = '1;
                    ro_d = nraw_q;
                end else begin
                    qo_d = negq_q ? -quo_q : quo_q;
                    ro_d = negr_q ? -rem_lo : rem_lo;
                end
                dzo_d   = dz_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            nsh_q     <= '0;
            rem_q     <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            nraw_q    <= '0;
            dz_q      <= 1'b0;
            valid_out <= 1'b0;
            q_out     <= '0;
            r_out     <= '0;
            dz_out    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nsh_q     <= nsh_d;
            rem_q     <= rem_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            nraw_q    <= nraw_d;
            dz_q      <= dz_d;
            valid_out <= valid_d;
            q_out     <= qo_d;
            r_out     <= ro_d;
            dz_out    <= dzo_d;
        end
    end

    assign busy_out = (state_q != StIdle);

endmodule

// File: tb/tb_relm_divider_seq.sv
// Bench for relm_divider_seq (WD=32). It runs directed and random operations and compares
// each result against a plain-arithmetic truncating-division model.
module tb_relm_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        signed_in;
    logic [31:0] n_in;
    logic [31:0] d_in;
    logic        busy_out;
    logic        valid_out;
    logic [31:0] q_out;
    logic [31:0] r_out;
    logic        dz_out;

    int passed = 0;
    int total  = 0;

    relm_divider_seq #(.WD(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .signed_in (signed_in),
        .n_in      (n_in),
        .d_in      (d_in),
        .busy_out  (busy_out),
        .valid_out (valid_out),
        .q_out     (q_out),
        .r_out     (r_out),
        .dz_out    (dz_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Truncating division computed with 64-bit arithmetic.
    function automatic void model(input logic [31:0] n, input logic [31:0] d, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
        longint nv;
        longint dv;
        if (d == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = n;
            dz = 1'b1;
        end else begin
            if (s) begin
                nv = longint'($signed(n));
                dv = longint'($signed(d));
            end else begin
                nv = longint'({32'd0, n});
                dv = longint'({32'd0, d});
            end
            q  = 32'(nv / dv);
            r  = 32'(nv % dv);
            dz = 1'b0;
        end
    endfunction

    // Called at the negedge just after the accepting edge; returns edges until valid_out.
    task automatic wait_valid(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!valid_out && lat < 40) begin
            if (busy_out) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                          input logic s);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          lat;
        int          bcnt;
        model(n, d, s, eq, er, edz);
        @(negedge clk);
        start_in  = 1'b1;
        n_in      = n;
        d_in      = d;
        signed_in = s;
        @(negedge clk);
        start_in = 1'b0;
        wait_valid(lat, bcnt);
        chk({tag, " latency"}, 32'(lat), 32'd17);
        chk({tag, " busy"}, 32'(bcnt), 32'd17);
        chk({tag, " busy_low"}, 32'(busy_out), 32'd0);
        chk({tag, " q"}, q_out, eq);
        chk({tag, " r"}, r_out, er);
        chk({tag, " dz"}, 32'(dz_out), 32'(edz));
    endtask

    initial begin
        int          lat;
        int          bcnt;
        logic [31:0] rn;
        logic [31:0] rd;
        logic        rs;
        rst       = 1'b1;
        start_in  = 1'b0;
        signed_in = 1'b0;
        n_in      = '0;
        d_in      = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy_out), 32'd0);
        chk("rst valid", 32'(valid_out), 32'd0);
        chk("rst q", q_out, 32'd0);
        chk("rst r", r_out, 32'd0);
        chk("rst dz", 32'(dz_out), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op("u100/7", 32'd100, 32'd7, 1'b0);
        run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("u-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("umax/1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("dz_u", 32'd5, 32'd0, 1'b0);
        run_op("dz_s", 32'd5, 32'd0, 1'b1);
        run_op("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("u/min", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        // A start while busy is ignored
        @(negedge clk);
        start_in = 1'b1; signed_in = 1'b0; n_in = 32'd100; d_in = 32'd7;
        @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        start_in = 1'b1; n_in = 32'd9; d_in = 32'd3;
        @(negedge clk);
        start_in = 1'b0;
        wait_valid(lat, bcnt);
        chk("hs_ignore latency", 32'(lat + 5), 32'd17);
        chk("hs_ignore q", q_out, 32'd14);
        chk("hs_ignore r", r_out, 32'd2);
        // A start during the valid cycle is accepted
        start_in = 1'b1; n_in = 32'd9; d_in = 32'd3;
        @(negedge clk);
        start_in = 1'b0;
        chk("hs_hold q", q_out, 32'd14);
        wait_valid(lat, bcnt);
        chk("hs_b2b latency", 32'(lat), 32'd17);
        chk("hs_b2b q", q_out, 32'd3);
        chk("hs_b2b r", r_out, 32'd0);

        // Reset mid-operation
        @(negedge clk);
        start_in = 1'b1; n_in = 32'd100; d_in = 32'd7;
        @(negedge clk);
        start_in = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy_out), 32'd0);
        chk("midrst valid", 32'(valid_out), 32'd0);
        chk("midrst q", q_out, 32'd0);
        chk("midrst r", r_out, 32'd0);
        chk("midrst dz", 32'(dz_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst 20/6", 32'd20, 32'd6, 1'b0);

        // Random operations with biased operand classes
        for (int i = 0; i < 150; i++) begin
            rn = $urandom;
            rd = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: rd = 32'($urandom_range(1, 15));
                1: rd = -32'($urandom_range(1, 15));
                2: rd = 32'd0;
                3: begin rn = 32'h8000_0000; rd = 32'hFFFF_FFFF; end
                4: rn = 32'($urandom_range(0, 1000));
                5: rd = rd >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op("rand", rn, rd, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
